// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch/issue stage: regfile read, scoreboard hazard stall, writeback bypass
module operand_fetch #(
  parameter bit REG_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_ra,
  input  logic [3:0]  in_rb,
  input  logic [3:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_wb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_opcode,
  output logic [31:0] out_left,
  output logic [31:0] out_right,
  output logic [3:0]  out_rd,
  output logic        out_wb,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data
);

  logic [31:0] regs [16];
  logic [15:0] pending;
  logic [15:0] clr_mask;
  logic [15:0] set_mask;
  logic [15:0] busy_vec;
  logic [31:0] left_val;
  logic [31:0] rb_val;
  logic [31:0] right_val;
  logic        hazard;
  logic        accept;
  logic        wb_write;

  assign wb_write = wb_en && !(REG_ZERO && (wb_reg == 4'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so a dependent instruction issues without a bubble.
  always_comb begin
    left_val = regs[in_ra];
    if (REG_ZERO && (in_ra == 4'd0)) begin
      left_val = '0;
    end else if (wb_en && (wb_reg == in_ra)) begin
      left_val = wb_data;
    end
  end

  always_comb begin
    rb_val = regs[in_rb];
    if (REG_ZERO && (in_rb == 4'd0)) begin
      rb_val = '0;
    end else if (wb_en && (wb_reg == in_rb)) begin
      rb_val = wb_data;
    end
  end

  assign right_val = in_use_imm ? {{16{in_imm[15]}}, in_imm} : rb_val;

  assign clr_mask = wb_en ? (16'd1 << wb_reg) : 16'd0;
  assign busy_vec = pending & ~clr_mask;

  assign hazard = busy_vec[in_ra]
                | (!in_use_imm & busy_vec[in_rb])
                | (in_wb & busy_vec[in_rd]);

  assign in_ready = reset_n & !hazard & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign set_mask = (accept && in_wb && !(REG_ZERO && (in_rd == 4'd0)))
                  ? (16'd1 << in_rd) : 16'd0;

  // Set is applied after clear so a same-cycle reissue keeps the bit pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_rd     <= '0;
      out_wb     <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_left   <= left_val;
      out_right  <= right_val;
      out_rd     <= in_rd;
      out_wb     <= in_wb;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [3:0]  in_rd;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        in_wb;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [31:0] out_left;
  logic [31:0] out_right;
  logic [3:0]  out_rd;
  logic        out_wb;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;

  int checks = 0;
  int passed = 0;

  operand_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_wb      (in_wb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_rd     (out_rd),
    .out_wb     (out_wb),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rd, input logic [15:0] imm,
                       input logic use_imm, input logic wbf);
    in_valid   = v;
    in_opcode  = op;
    in_ra      = ra;
    in_rb      = rb;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_wb      = wbf;
  endtask

  task automatic wback(input logic en, input logic [3:0] r, input logic [31:0] d);
    wb_en   = en;
    wb_reg  = r;
    wb_data = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    issue(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0);
    wback(1'b0, 4'd0, 32'd0);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_left", out_left, 32'd0);
    check("reset_out_right", out_right, 32'd0);
    check("reset_out_opcode", {28'd0, out_opcode}, 32'd0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;

    // basic read with sign-extended immediate
    wback(1'b1, 4'd3, 32'h12345678);
    tick();
    wback(1'b0, 4'd0, 32'd0);
    issue(1'b1, 4'd2, 4'd3, 4'd0, 4'd1, 16'hFFFF, 1'b1, 1'b0);
    #1;
    check("basic_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("basic_out_valid", {31'd0, out_valid}, 32'd1);
    check("basic_out_opcode", {28'd0, out_opcode}, 32'd2);
    check("basic_out_left", out_left, 32'h12345678);
    check("basic_out_right", out_right, 32'hFFFFFFFF);
    check("basic_out_rd", {28'd0, out_rd}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_hold_left", out_left, 32'h12345678);

    // RAW stall then bypass on writeback cycle
    issue(1'b1, 4'd1, 4'd0, 4'd0, 4'd5, 16'd0, 1'b1, 1'b1);
    tick();
    check("raw_prod_wb", {31'd0, out_wb}, 32'd1);
    issue(1'b1, 4'd3, 4'd5, 4'd0, 4'd6, 16'h0001, 1'b1, 1'b0);
    #1;
    check("raw_stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("raw_stall_ready2", {31'd0, in_ready}, 32'd0);
    check("raw_stall_valid", {31'd0, out_valid}, 32'd0);
    wback(1'b1, 4'd5, 32'h000000A5);
    #1;
    check("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wback(1'b0, 4'd0, 32'd0);
    check("raw_bypass_valid", {31'd0, out_valid}, 32'd1);
    check("raw_bypass_left", out_left, 32'h000000A5);
    check("raw_bypass_right", out_right, 32'h00000001);

    // r0 hardwired to zero and never pending
    in_valid = 1'b0;
    wback(1'b1, 4'd0, 32'h0000DEAD);
    tick();
    wback(1'b0, 4'd0, 32'd0);
    issue(1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b1);
    tick();
    check("r0_left", out_left, 32'd0);
    check("r0_right", out_right, 32'd0);
    issue(1'b1, 4'd6, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b1);
    #1;
    check("r0_no_stall", {31'd0, in_ready}, 32'd1);
    tick();
    check("r0_second_valid", {31'd0, out_valid}, 32'd1);
    check("r0_second_opcode", {28'd0, out_opcode}, 32'd6);
    in_valid = 1'b0;
    tick();

    // backpressure: outputs held stable while out_ready is low
    out_ready = 1'b0;
    issue(1'b1, 4'd9, 4'd3, 4'd0, 4'd2, 16'h0007, 1'b1, 1'b0);
    tick();
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    issue(1'b1, 4'd4, 4'd5, 4'd0, 4'd2, 16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_hold_opcode", {28'd0, out_opcode}, 32'd9);
      check("bp_hold_left", out_left, 32'h12345678);
      check("bp_hold_right", out_right, 32'h00000007);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_next_opcode", {28'd0, out_opcode}, 32'd4);
    check("bp_next_left", out_left, 32'h000000A5);
    check("bp_next_right", out_right, 32'hFFFF8000);

    // WAW stall; reissue on the writeback cycle keeps r7 pending
    issue(1'b1, 4'd1, 4'd0, 4'd0, 4'd7, 16'd0, 1'b1, 1'b1);
    tick();
    issue(1'b1, 4'd2, 4'd0, 4'd0, 4'd7, 16'd0, 1'b1, 1'b1);
    #1;
    check("waw_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("waw_stall2", {31'd0, in_ready}, 32'd0);
    wback(1'b1, 4'd7, 32'h00000077);
    #1;
    check("waw_release", {31'd0, in_ready}, 32'd1);
    tick();
    wback(1'b0, 4'd0, 32'd0);
    check("waw_second_opcode", {28'd0, out_opcode}, 32'd2);
    issue(1'b1, 4'd3, 4'd7, 4'd0, 4'd8, 16'd0, 1'b1, 1'b0);
    #1;
    check("waw_set_wins", {31'd0, in_ready}, 32'd0);
    tick();
    check("waw_still_pending", {31'd0, in_ready}, 32'd0);

    // asynchronous reset mid-stall
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_valid", {31'd0, out_valid}, 32'd0);
    check("areset_ready", {31'd0, in_ready}, 32'd0);
    check("areset_left", out_left, 32'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    issue(1'b1, 4'd7, 4'd7, 4'd3, 4'd9, 16'd0, 1'b0, 1'b0);
    #1;
    check("post_reset_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("post_reset_valid", {31'd0, out_valid}, 32'd1);
    check("post_reset_r7", out_left, 32'd0);
    check("post_reset_r3", out_right, 32'd0);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
